// File: rtl/led_rotator_pkg.sv
// led_rotator_pkg
//   Shared types and helpers for the led_rotator block.
//   - state_e      : rotator FSM states (static view / running pattern)
//   - DIR_LEFT/RIGHT: encoding of the dir input
//   - rot_left()   : left rotation of a vector whose live width is a
//                    runtime argument, so the same helper serves every WIDTH
//   Optional feature macro used by the block: LED_ROTATOR_DEBOUNCE_EN.
package led_rotator_pkg;

  typedef enum logic {
    ST_STATIC = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;  // step towards MSB
  localparam logic DIR_RIGHT = 1'b1;  // step towards LSB

  // Widest vector rot_left() can handle; callers zero-extend into it.
  localparam int unsigned ROT_MAX_W = 64;
  localparam int unsigned ROT_IDX_W = $clog2(ROT_MAX_W);

  // Left rotation of the low w bits of v by n places (n reduced modulo w).
  // Output bit i = v[(i - n) mod w]; bits at or above w are zero.
  function automatic logic [ROT_MAX_W-1:0] rot_left(
    input logic [ROT_MAX_W-1:0] v,
    input int unsigned          n,
    input int unsigned          w
  );
    logic [ROT_MAX_W-1:0] r;
    logic [ROT_IDX_W-1:0] src;
    int unsigned          k;
    r   = '0;
    k   = n % w;
    src = '0;
    for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
      if (i < w) begin
        // (i - k) mod w, kept non-negative by adding w first
        src = ROT_IDX_W'((i + w - k) % w);
        r[ROT_IDX_W'(i)] = v[src];
      end else begin
        r[ROT_IDX_W'(i)] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_rotator_if.sv
// led_rotator_if
//   Bundles the switch/LED side of led_rotator.
//   switches   : raw asynchronous switch levels      (master -> slave)
//   shift      : left-rotation amount, clk domain    (master -> slave)
//   run        : 1 = run mode                        (master -> slave)
//   dir        : 0 = step left, 1 = step right       (master -> slave)
//   leds       : registered LED drive                (slave -> master)
//   step_pulse : one-cycle pulse per run-mode step   (slave -> master)
//   Modports: master (board / bench side), slave (led_rotator).
//   Used together with the LED_ROTATOR_DEBOUNCE_EN build option of the top.
interface led_rotator_if #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0]   switches;
  logic [SHIFT_W-1:0] shift;
  logic               run;
  logic               dir;
  logic [WIDTH-1:0]   leds;
  logic               step_pulse;

  modport master (
    output switches, shift, run, dir,
    input  leds, step_pulse
  );

  modport slave (
    input  switches, shift, run, dir,
    output leds, step_pulse
  );
endinterface

// File: rtl/led_rotator_switch_debounce.sv
// switch_debounce
//   2-flop synchroniser plus whole-vector debouncer for the led_rotator
//   switch inputs. Instantiated only when LED_ROTATOR_DEBOUNCE_EN is defined.
//   Ports:
//     i_clk, i_rst : clock, asynchronous active-high reset
//     i_sw         : raw switch levels
//     o_sw_db      : debounced switch vector (registered)
//     o_upd        : high for the cycle in which o_sw_db holds a new value
module switch_debounce
  import led_rotator_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw_db,
  output logic             o_upd
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_sw_db;
  logic [DB_W-1:0]  r_cnt;
  logic             r_upd;

  logic             w_changed;
  logic [DB_W-1:0]  w_cnt_next;
  logic             w_load;

  // Stability counter: counts cycles the synchronised vector has held,
  // including the current one, saturating at DEBOUNCE_CYCLES.
  always_comb begin
    w_changed = (r_sync2 != r_last);
    if (w_changed) begin
      w_cnt_next = DB_W'(1);
    end else if (r_cnt == DB_MAX) begin
      w_cnt_next = DB_MAX;
    end else begin
      w_cnt_next = r_cnt + DB_W'(1);
    end
    // Load once, on the cycle the count first reaches the threshold
    w_load = (w_cnt_next == DB_MAX) && ((r_cnt != DB_MAX) || w_changed);
  end

  // Synchroniser, counter and debounced output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_sw_db <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_sw_db <= r_sync2;
      end
      // Reloading an identical value is not reported as an update
      r_upd <= w_load && (r_sync2 != r_sw_db);
    end
  end

  assign o_sw_db = r_sw_db;
  assign o_upd   = r_upd;

endmodule

// File: rtl/led_rotator.sv
// led_rotator
//   Board-edge switch-to-LED rotator. Static mode shows the (debounced)
//   switches rotated left by 'shift'; run mode marches a latched pattern
//   around the ring one place every PERIOD cycles.
//   Ports:
//     i_clk : sole clock, rising edge
//     i_rst : asynchronous active-high reset
//     bus   : led_rotator_if.slave (switches, shift, run, dir in;
//             leds, step_pulse out)
//   Parameters: WIDTH (>= 2), DEBOUNCE_CYCLES (>= 1), PERIOD (>= 1).
//   Build option LED_ROTATOR_DEBOUNCE_EN: when defined, switches pass
//   through switch_debounce; otherwise only a bare 2-flop synchroniser.
module led_rotator
  import led_rotator_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD          = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  led_rotator_if.slave bus
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "led_rotator: WIDTH must be >= 2");
    end
    if (WIDTH > ROT_MAX_W) begin : g_wide_width
      $fatal(1, "led_rotator: WIDTH exceeds rot_left capacity");
    end
    if (PERIOD < 1) begin : g_bad_period
      $fatal(1, "led_rotator: PERIOD must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $fatal(1, "led_rotator: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] w_sw_db;
  logic             w_sw_upd;

`ifdef LED_ROTATOR_DEBOUNCE_EN
  switch_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_switch_debounce (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sw    (bus.switches),
    .o_sw_db (w_sw_db),
    .o_upd   (w_sw_upd)
  );
`else
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic             r_sync_upd;

  // Bare 2-flop synchroniser; the update flag marks a new value in r_sync2
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync_upd <= 1'b0;
    end else begin
      r_sync1    <= bus.switches;
      r_sync2    <= r_sync1;
      r_sync_upd <= (r_sync1 != r_sync2);
    end
  end

  assign w_sw_db  = r_sync2;
  assign w_sw_upd = r_sync_upd;
`endif

  state_e           r_state;
  logic [WIDTH-1:0] r_pattern;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_leds;
  logic             r_step;

  state_e           w_state_next;
  logic [WIDTH-1:0] w_pattern_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_leds_next;
  logic             w_step_next;
  logic [WIDTH-1:0] w_static_view;
  logic [WIDTH-1:0] w_stepped;

  // Static view and the one-place step of the running pattern
  always_comb begin
    w_static_view = WIDTH'(rot_left(ROT_MAX_W'(w_sw_db), 32'(bus.shift), WIDTH));
    if (bus.dir == DIR_RIGHT) begin
      w_stepped = {r_pattern[0], r_pattern[WIDTH-1:1]};
    end else begin
      w_stepped = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
    end
  end

  // FSM next-state and output decode
  always_comb begin
    w_state_next   = r_state;
    w_pattern_next = r_pattern;
    w_cnt_next     = r_cnt;
    w_leds_next    = r_leds;
    w_step_next    = 1'b0;
    case (r_state)
      ST_STATIC: begin
        w_leds_next = w_static_view;
        w_cnt_next  = '0;
        if (bus.run) begin
          w_state_next   = ST_RUN;
          w_pattern_next = w_static_view;
        end else begin
          w_state_next = ST_STATIC;
        end
      end
      ST_RUN: begin
        if (!bus.run) begin
          w_state_next = ST_STATIC;
          w_cnt_next   = '0;
          w_leds_next  = w_static_view;
        end else if (w_sw_upd) begin
          // New switch value wins over a step due in the same cycle
          w_pattern_next = w_static_view;
          w_leds_next    = w_static_view;
          w_cnt_next     = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_pattern_next = w_stepped;
          w_leds_next    = w_stepped;
          w_cnt_next     = '0;
          w_step_next    = 1'b1;
        end else begin
          w_cnt_next  = r_cnt + CNT_W'(1);
          w_leds_next = r_pattern;
        end
      end
      default: begin
        w_state_next   = ST_STATIC;
        w_pattern_next = '0;
        w_cnt_next     = '0;
        w_leds_next    = '0;
      end
    endcase
  end

  // FSM state, pattern, period counter and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_STATIC;
      r_pattern <= '0;
      r_cnt     <= '0;
      r_leds    <= '0;
      r_step    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pattern <= w_pattern_next;
      r_cnt     <= w_cnt_next;
      r_leds    <= w_leds_next;
      r_step    <= w_step_next;
    end
  end

  assign bus.leds       = r_leds;
  assign bus.step_pulse = r_step;

endmodule

// File: tb/tb_led_rotator.sv
// tb_led_rotator
//   Directed bench for led_rotator: an 8-wide instance (DEBOUNCE_CYCLES=4,
//   PERIOD=4) and a 6-wide instance (DEBOUNCE_CYCLES=2, PERIOD=1).
//   Expected latencies follow LED_ROTATOR_DEBOUNCE_EN as compiled.
module tb_led_rotator;
  import led_rotator_pkg::*;

`ifdef LED_ROTATOR_DEBOUNCE_EN
  localparam int DB_LAT  = 4;
  localparam int DB_LAT6 = 2;
`else
  localparam int DB_LAT  = 0;
  localparam int DB_LAT6 = 0;
`endif
  localparam int SW_LAT  = 2 + DB_LAT;   // raw switches -> sw_db
  localparam int LED_LAT = SW_LAT + 1;   // raw switches -> leds

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  led_rotator_if #(.WIDTH(8)) if8 ();
  led_rotator_if #(.WIDTH(6)) if6 ();

  led_rotator #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .PERIOD(4)) u_dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if8)
  );

  led_rotator #(.WIDTH(6), .DEBOUNCE_CYCLES(2), .PERIOD(1)) u_dut6 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] step_l [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] step_r [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] exp_leds;
    logic       exp_step;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    if8.switches = 8'h00; if8.shift = 3'd0; if8.run = 1'b0; if8.dir = DIR_LEFT;
    if6.switches = 6'h00; if6.shift = 3'd0; if6.run = 1'b0; if6.dir = DIR_LEFT;

    // Reset state
    tick(); tick(); tick();
    check_eq("reset_leds", 32'(if8.leds), 32'h00);
    check_eq("reset_step", 32'(if8.step_pulse), 32'h0);
    rst = 1'b0;
    tick(); tick();
    check_eq("post_reset_leds", 32'(if8.leds), 32'h00);

    // Glitch: 0x01 for 3 cycles then back to 0x00
    if8.switches = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) if8.switches = 8'h00;
      tick();
      exp_leds = (DB_LAT == 0 && k >= 3 && k <= 5) ? 8'h01 : 8'h00;
      check_eq($sformatf("glitch_k%0d", k), 32'(if8.leds), 32'(exp_leds));
    end
    for (int k = 0; k < 8; k++) tick();

    // Static rotation, shift = 5, latency check
    if8.shift = 3'd5;
    if8.switches = 8'h01;
    for (int k = 1; k < LED_LAT; k++) tick();
    check_eq("static_before", 32'(if8.leds), 32'h00);
    tick();
    check_eq("static_shift5", 32'(if8.leds), 32'h20);
    if8.shift = 3'd0;
    tick();
    check_eq("static_shift0", 32'(if8.leds), 32'h01);

    // Run mode, left then right, full ring
    for (int d = 0; d < 2; d++) begin
      if8.dir = (d == 0) ? DIR_LEFT : DIR_RIGHT;
      if8.run = 1'b1;
      tick();
      check_eq($sformatf("run%0d_entry", d), 32'(if8.leds), 32'h01);
      check_eq($sformatf("run%0d_entry_step", d), 32'(if8.step_pulse), 32'h0);
      prev = 8'h01;
      for (int s = 0; s < 8; s++) begin
        for (int c = 0; c < 3; c++) begin
          tick();
          check_eq($sformatf("run%0d_hold_s%0d", d, s), {23'd0, if8.step_pulse, if8.leds},
                   {23'd0, 1'b0, prev});
        end
        tick();
        exp_leds = (d == 0) ? step_l[s] : step_r[s];
        check_eq($sformatf("run%0d_step_s%0d", d, s), {23'd0, if8.step_pulse, if8.leds},
                 {23'd0, 1'b1, exp_leds});
        prev = exp_leds;
      end
      if8.run = 1'b0;
      tick();
      check_eq($sformatf("run%0d_exit", d), {23'd0, if8.step_pulse, if8.leds}, 32'h001);
    end

    // Reload priority: sw_db update coincides with the second step
    if8.dir = DIR_LEFT;
    if8.run = 1'b1;
    tick();
    check_eq("reload_entry", 32'(if8.leds), 32'h01);
    if8.shift = 3'd2;  // must not affect pattern until the reload
    for (int t = 1; t <= 12; t++) begin
      if (t - 1 == 7 - SW_LAT) if8.switches = 8'h03;
      tick();
      if (t < 4)       begin exp_leds = 8'h01; exp_step = 1'b0; end
      else if (t == 4) begin exp_leds = 8'h02; exp_step = 1'b1; end
      else if (t < 8)  begin exp_leds = 8'h02; exp_step = 1'b0; end
      else if (t < 12) begin exp_leds = 8'h0C; exp_step = 1'b0; end
      else             begin exp_leds = 8'h18; exp_step = 1'b1; end
      check_eq($sformatf("reload_t%0d", t), {23'd0, if8.step_pulse, if8.leds},
               {23'd0, exp_step, exp_leds});
    end
    if8.run = 1'b0;
    tick();
    check_eq("reload_exit", {23'd0, if8.step_pulse, if8.leds}, 32'h00C);

    // Reset mid-RUN, just after a step
    if8.run = 1'b1;
    tick();
    check_eq("mid_entry", 32'(if8.leds), 32'h0C);
    tick(); tick(); tick(); tick();
    check_eq("mid_step", {23'd0, if8.step_pulse, if8.leds}, 32'h118);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_leds", 32'(if8.leds), 32'h00);
    check_eq("mid_rst_step", 32'(if8.step_pulse), 32'h0);
    if8.run = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k < LED_LAT; k++) tick();
    check_eq("after_rst_before", 32'(if8.leds), 32'h00);
    tick();
    check_eq("after_rst_static", 32'(if8.leds), 32'h0C);

    // WIDTH=6: modulo shift and PERIOD=1 stepping
    if6.switches = 6'h01;
    if6.shift = 3'd7;
    for (int k = 0; k < 3 + DB_LAT6 + 2; k++) tick();
    check_eq("w6_modshift", 32'(if6.leds), 32'h02);
    if6.run = 1'b1;
    tick();
    check_eq("w6_entry", {25'd0, if6.step_pulse, if6.leds}, {25'd0, 1'b0, 6'h02});
    tick();
    check_eq("w6_step1", {25'd0, if6.step_pulse, if6.leds}, {25'd0, 1'b1, 6'h04});
    tick();
    check_eq("w6_step2", {25'd0, if6.step_pulse, if6.leds}, {25'd0, 1'b1, 6'h08});
    if6.dir = DIR_RIGHT;
    tick();
    check_eq("w6_step_right", {25'd0, if6.step_pulse, if6.leds}, {25'd0, 1'b1, 6'h04});
    if6.run = 1'b0;
    tick();
    check_eq("w6_exit", {25'd0, if6.step_pulse, if6.leds}, {25'd0, 1'b0, 6'h02});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_rotator.md
# led_rotator

Parametrised, clocked successor to the fixed LED/switch rotation block. It samples raw switches through a synchroniser and optional debouncer, then drives the LEDs in one of two modes. In static mode the LEDs show the switch vector rotated left by a runtime amount. In run mode the pattern marches around the LED ring at a programmable rate. It sits at the board-level I/O edge, between the physical switches and the LED pins.

## Interface
- WIDTH, 8: number of switches and LEDs; must be ≥ 2 (elaboration-time fatal otherwise)
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a switch change is accepted; ≥ 1
- PERIOD, 16: clock cycles per rotation step in run mode; ≥ 1
- SHIFT_W, derived = $clog2(WIDTH): width of the shift port
- clk  in  1  sole clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- switches  in  WIDTH  raw, asynchronous switch levels
- shift  in  SHIFT_W  left-rotation amount, synchronous to clk; values ≥ WIDTH are reduced modulo WIDTH
- run  in  1  level, synchronous; 1 selects run mode
- dir  in  1  synchronous; 0 = step left (towards MSB), 1 = step right
- leds  out  WIDTH  registered LED drive
- step_pulse  out  1  one-cycle pulse, high in the cycle the run-mode pattern advances

## Operation
- Input path: 2-flop synchroniser on all switches bits, followed by a debouncer producing sw_db.
  - Debouncer: a single counter guards the whole vector.
  - Any change of the synchronised vector restarts the count.
  - sw_db loads the synchronised vector once it has been unchanged for DEBOUNCE_CYCLES consecutive cycles.
- rot(v, n): left rotation by n. Output bit i = v[(i − n) mod WIDTH].
- FSM, two states:
  - STATIC (reset state):
    - leds ← rot(sw_db, shift) every cycle.
    - If run = 1: load pattern ← rot(sw_db, shift), clear the period counter, go to RUN.
  - RUN:
    - leds = pattern.
    - The period counter counts 0..PERIOD−1 and wraps.
    - On wrap: pattern rotates one place per dir, and step_pulse = 1.
    - If run = 0: go to STATIC. The period counter is cleared.
- Priority in RUN:
  - A sw_db update reloads pattern ← rot(new sw_db, shift) and clears the counter.
  - This reload overrides a step coinciding in the same cycle; no step_pulse is issued for that cycle.
- A change of shift in RUN takes effect only at the next reload.
- A change of dir in RUN takes effect at the next step.
- PERIOD = 1: the pattern steps every cycle while in RUN.

## Timing
- Reset: leds = 0, step_pulse = 0, state STATIC. Synchroniser, sw_db, debounce counter, period counter and pattern all = 0.
- Static latency, raw switches change to leds:
  - With debounce: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Without debounce: 3 cycles.
- shift change in STATIC: visible on leds 1 cycle later.
- run 0→1:
  - RUN is entered at the next edge; leds show the loaded pattern at that edge.
  - The first step happens PERIOD cycles after entry, then every PERIOD cycles.
- run 1→0: STATIC at the next edge; leds show the static view from that edge.
- step_pulse is high in exactly the cycle in which leds shows the newly rotated value.
- Wrap-around: WIDTH steps in one direction return the original pattern.
- Reset mid-operation: outputs clear asynchronously. Normal operation resumes at the first edge after rst is released.

## Configuration
- LED_ROTATOR_DEBOUNCE_EN:
  - Defined: debouncer instantiated as described above.
  - Undefined: sw_db is the synchroniser output directly, with no filtering. DEBOUNCE_CYCLES is ignored, and static latency is 3 cycles.

## Structure
- led_rotator_pkg holds:
  - the state enum (STATIC, RUN)
  - a dir encoding constant pair
  - a rotate-left function parametrised on width, used for both static view and reload
- One sub-module: switch_debounce, which contains the synchroniser, counter and sw_db register.
  - Instantiated only under LED_ROTATOR_DEBOUNCE_EN; otherwise only a bare 2-flop synchroniser is used.

## Test plan
- Static rotation: WIDTH = 8, shift = 5, switches 0x00→0x01 held → leds = 0x20 exactly 7 cycles later (DEBOUNCE_CYCLES = 4); shift → 0 gives leds = 0x01 one cycle later.
- Glitch rejection: switches pulse 0x01 for 3 cycles then back to 0x00 → leds stay 0x00; the same stimulus with the macro undefined → leds = 0x01 for 3 cycles.
- Run mode: PERIOD = 4, shift = 0, sw_db = 0x01, run = 1, dir = 0 → leds 0x01, then 0x02 after 4 cycles with step_pulse; after 8 steps back to 0x01. Repeat with dir = 1 → first step gives 0x80.
- Modulo shift: WIDTH = 6, shift = 7, switches = 6'b000001 → leds = 6'b000010.
- Reload priority: in RUN, change switches so that sw_db updates on the same cycle as a scheduled step → pattern = rot(new, shift), no step_pulse, next step PERIOD cycles later.
- Reset mid-RUN: assert rst between edges → leds = 0 and step_pulse = 0 immediately. Release with run = 0 → STATIC, leds track switches with the nominal latency.
